// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding plus load-use / memory-busy stall control for the
// 5-stage pipeline. Forward selects are combinational; stall state is registered.
module fwd_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int ZERO_REG = 31,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_src,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic [REG_AW-1:0]           idex_rd,
    input  logic                        idex_memread,
    input  logic [REG_AW-1:0]           exmem_rd,
    input  logic                        exmem_regwrite,
    input  logic [REG_AW-1:0]           memwb_rd,
    input  logic                        memwb_regwrite,
    input  logic                        mem_busy,
    output logic [2*NUM_SRC-1:0]        fwd_sel,
    output logic                        pc_hold,
    output logic                        ifid_hold,
    output logic                        idex_bubble,
    output logic                        pipe_freeze,
    output logic [CNT_W-1:0]            stall_cycles,
    output logic                        dbg_st
);

    localparam logic [REG_AW-1:0] ZR        = REG_AW'(ZERO_REG);
    localparam logic [2:0]        WAIT_INIT = 3'(LOAD_LAT - 1);
    localparam bit                MULTI_LAT = (LOAD_LAT > 1);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_LU_WAIT = 1'b1
    } st_e;

    st_e              st_q;
    logic [2:0]       wcnt_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;

    logic             exmem_fwd_ok;
    logic             memwb_fwd_ok;
    logic [NUM_SRC-1:0] lu_hit;
    logic             lu;
    logic             stall_req;

    // A write to the zero register is architecturally discarded, so it is
    // never a forwarding source.
    assign exmem_fwd_ok = exmem_regwrite && (exmem_rd != ZR);
    assign memwb_fwd_ok = memwb_regwrite && (memwb_rd != ZR);

    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (exmem_fwd_ok && (exmem_rd == ex_src[i*REG_AW +: REG_AW])) begin
                fwd_sel[2*i +: 2] = 2'b10;
            end else if (memwb_fwd_ok && (memwb_rd == ex_src[i*REG_AW +: REG_AW])) begin
                fwd_sel[2*i +: 2] = 2'b01;
            end
        end
    end

    always_comb begin
        lu_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            lu_hit[i] = id_src_used[i] && (id_src[i*REG_AW +: REG_AW] == idex_rd);
        end
    end

    assign lu = idex_memread && (idex_rd != ZR) && (|lu_hit);

    // While waiting out the load latency the stall is unconditional; lu only
    // matters for starting a new stall from RUN.
    assign stall_req   = (st_q == ST_LU_WAIT) || lu;
    assign pipe_freeze = mem_busy;
    assign pc_hold     = mem_busy || stall_req;
    assign ifid_hold   = mem_busy || stall_req;
    assign idex_bubble = !mem_busy && stall_req;

    assign stall_d      = (pc_hold && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
    assign stall_cycles = stall_q;
    assign dbg_st       = st_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= ST_RUN;
            wcnt_q  <= 3'd0;
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
            // A busy data memory freezes the whole back end, including this FSM.
            if (!mem_busy) begin
                case (st_q)
                    ST_RUN: begin
                        if (lu && MULTI_LAT) begin
                            st_q   <= ST_LU_WAIT;
                            wcnt_q <= WAIT_INIT;
                        end
                    end
                    ST_LU_WAIT: begin
                        wcnt_q <= wcnt_q - 3'd1;
                        if (wcnt_q <= 3'd1) begin
                            st_q <= ST_RUN;
                        end
                    end
                    default: begin
                        st_q   <= ST_RUN;
                        wcnt_q <= 3'd0;
                    end
                endcase
            end
        end
    end

    a_no_bubble_when_frozen : assert property (@(posedge clk) disable iff (!rst_n)
        !(idex_bubble && pipe_freeze));

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: three instances (LOAD_LAT=1, LOAD_LAT=3,
// CNT_W=4) share one set of inputs; each scenario checks the relevant instance.
module tb_fwd_hazard_unit;

    logic        clk;
    logic        rst_n;
    logic [9:0]  ex_src;
    logic [9:0]  id_src;
    logic [1:0]  id_src_used;
    logic [4:0]  idex_rd;
    logic        idex_memread;
    logic [4:0]  exmem_rd;
    logic        exmem_regwrite;
    logic [4:0]  memwb_rd;
    logic        memwb_regwrite;
    logic        mem_busy;

    logic [3:0]  fwd_a, fwd_b, fwd_c;
    logic        pch_a, pch_b, pch_c;
    logic        ifh_a, ifh_b, ifh_c;
    logic        bub_a, bub_b, bub_c;
    logic        frz_a, frz_b, frz_c;
    logic [31:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;
    logic        st_a, st_b, st_c;

    int n_tests = 0;
    int n_fail  = 0;

    fwd_hazard_unit #(.LOAD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .ex_src(ex_src), .id_src(id_src),
        .id_src_used(id_src_used), .idex_rd(idex_rd), .idex_memread(idex_memread),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .memwb_rd(memwb_rd),
        .memwb_regwrite(memwb_regwrite), .mem_busy(mem_busy), .fwd_sel(fwd_a),
        .pc_hold(pch_a), .ifid_hold(ifh_a), .idex_bubble(bub_a), .pipe_freeze(frz_a),
        .stall_cycles(cnt_a), .dbg_st(st_a)
    );

    fwd_hazard_unit #(.LOAD_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .ex_src(ex_src), .id_src(id_src),
        .id_src_used(id_src_used), .idex_rd(idex_rd), .idex_memread(idex_memread),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .memwb_rd(memwb_rd),
        .memwb_regwrite(memwb_regwrite), .mem_busy(mem_busy), .fwd_sel(fwd_b),
        .pc_hold(pch_b), .ifid_hold(ifh_b), .idex_bubble(bub_b), .pipe_freeze(frz_b),
        .stall_cycles(cnt_b), .dbg_st(st_b)
    );

    fwd_hazard_unit #(.CNT_W(4)) u_cnt4 (
        .clk(clk), .rst_n(rst_n), .ex_src(ex_src), .id_src(id_src),
        .id_src_used(id_src_used), .idex_rd(idex_rd), .idex_memread(idex_memread),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .memwb_rd(memwb_rd),
        .memwb_regwrite(memwb_regwrite), .mem_busy(mem_busy), .fwd_sel(fwd_c),
        .pc_hold(pch_c), .ifid_hold(ifh_c), .idex_bubble(bub_c), .pipe_freeze(frz_c),
        .stall_cycles(cnt_c), .dbg_st(st_c)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        ex_src         = '0;
        id_src         = '0;
        id_src_used    = '0;
        idex_rd        = '0;
        idex_memread   = 1'b0;
        exmem_rd       = '0;
        exmem_regwrite = 1'b0;
        memwb_rd       = '0;
        memwb_regwrite = 1'b0;
        mem_busy       = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Load in EX writes x3, decoding instruction reads x3 on operand 1.
    task automatic drive_load_use();
        idex_memread = 1'b1;
        idex_rd      = 5'd3;
        id_src       = {5'd3, 5'd0};
        id_src_used  = 2'b11;
    endtask

    initial begin
        clear_inputs();
        do_reset();
        settle();
        chk("reset_cnt_a", cnt_a, 32'd0);
        chk("reset_cnt_b", cnt_b, 32'd0);
        chk("reset_pch_a", {31'd0, pch_a}, 32'd0);
        chk("reset_st_b", {31'd0, st_b}, 32'd0);
        chk("reset_fwd_a", {28'd0, fwd_a}, 32'd0);

        // Forwarding priority and zero-register exclusion
        exmem_regwrite = 1'b1; exmem_rd = 5'd5;
        memwb_regwrite = 1'b1; memwb_rd = 5'd5;
        ex_src = {5'd5, 5'd5};
        settle();
        chk("fwd_exmem_prio", {28'd0, fwd_a}, 32'b1010);
        exmem_regwrite = 1'b0;
        settle();
        chk("fwd_memwb_only", {28'd0, fwd_a}, 32'b0101);
        exmem_regwrite = 1'b1; exmem_rd = 5'd31;
        memwb_rd = 5'd7;
        ex_src = {5'd7, 5'd31};
        settle();
        chk("fwd_xzr_rm", {28'd0, fwd_a}, 32'b0100);
        exmem_rd = 5'd2; memwb_rd = 5'd9;
        ex_src = {5'd9, 5'd2};
        settle();
        chk("fwd_mixed", {28'd0, fwd_a}, 32'b0110);
        memwb_rd = 5'd31; exmem_rd = 5'd4;
        ex_src = {5'd31, 5'd31};
        settle();
        chk("fwd_memwb_xzr", {28'd0, fwd_a}, 32'b0000);
        exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
        memwb_rd = 5'd6; exmem_rd = 5'd6;
        ex_src = {5'd6, 5'd6};
        settle();
        chk("fwd_no_regwrite", {28'd0, fwd_a}, 32'b0000);

        // LOAD_LAT=1: one-cycle stall
        do_reset();
        drive_load_use();
        settle();
        chk("lat1_pch", {31'd0, pch_a}, 32'd1);
        chk("lat1_ifh", {31'd0, ifh_a}, 32'd1);
        chk("lat1_bub", {31'd0, bub_a}, 32'd1);
        chk("lat1_frz", {31'd0, frz_a}, 32'd0);
        chk("lat1_cnt0", cnt_a, 32'd0);
        tick();
        idex_memread = 1'b0;
        settle();
        chk("lat1_pch_done", {31'd0, pch_a}, 32'd0);
        chk("lat1_bub_done", {31'd0, bub_a}, 32'd0);
        chk("lat1_cnt1", cnt_a, 32'd1);
        chk("lat1_st_run", {31'd0, st_a}, 32'd0);

        // Operand not read, or load into XZR: no stall
        drive_load_use();
        id_src_used = 2'b01;
        settle();
        chk("unused_pch", {31'd0, pch_a}, 32'd0);
        chk("unused_bub", {31'd0, bub_a}, 32'd0);
        idex_rd = 5'd31; id_src = {5'd31, 5'd31}; id_src_used = 2'b11;
        settle();
        chk("xzr_load_pch", {31'd0, pch_a}, 32'd0);
        tick();
        chk("unused_cnt", cnt_a, 32'd1);

        // LOAD_LAT=3: three stall cycles with bubble
        do_reset();
        drive_load_use();
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("lat3_pch_%0d", k), {31'd0, pch_b}, 32'd1);
            chk($sformatf("lat3_bub_%0d", k), {31'd0, bub_b}, 32'd1);
            tick();
            idex_memread = 1'b0;
            if (k == 0) begin
                settle();
                chk("lat3_st_wait", {31'd0, st_b}, 32'd1);
            end
        end
        settle();
        chk("lat3_pch_done", {31'd0, pch_b}, 32'd0);
        chk("lat3_st_run", {31'd0, st_b}, 32'd0);
        chk("lat3_cnt", cnt_b, 32'd3);

        // LOAD_LAT=3 with a two-cycle freeze inside LU_WAIT
        do_reset();
        drive_load_use();
        settle();
        chk("frz_pch_c0", {31'd0, pch_b}, 32'd1);
        tick();
        idex_memread = 1'b0;
        mem_busy     = 1'b1;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk($sformatf("frz_freeze_%0d", k), {31'd0, frz_b}, 32'd1);
            chk($sformatf("frz_bub_%0d", k), {31'd0, bub_b}, 32'd0);
            chk($sformatf("frz_pch_%0d", k), {31'd0, pch_b}, 32'd1);
            tick();
        end
        mem_busy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk($sformatf("frz_resume_bub_%0d", k), {31'd0, bub_b}, 32'd1);
            chk($sformatf("frz_resume_frz_%0d", k), {31'd0, frz_b}, 32'd0);
            tick();
        end
        settle();
        chk("frz_pch_done", {31'd0, pch_b}, 32'd0);
        chk("frz_cnt", cnt_b, 32'd5);

        // Asynchronous reset in the middle of LU_WAIT
        do_reset();
        drive_load_use();
        tick();
        idex_memread = 1'b0;
        tick();
        settle();
        chk("mid_pch_before", {31'd0, pch_b}, 32'd1);
        chk("mid_cnt_before", cnt_b, 32'd2);
        rst_n = 1'b0;
        settle();
        chk("mid_rst_pch", {31'd0, pch_b}, 32'd0);
        chk("mid_rst_ifh", {31'd0, ifh_b}, 32'd0);
        chk("mid_rst_bub", {31'd0, bub_b}, 32'd0);
        chk("mid_rst_cnt", cnt_b, 32'd0);
        chk("mid_rst_st", {31'd0, st_b}, 32'd0);
        tick();
        rst_n = 1'b1;
        drive_load_use();
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("fresh_pch_%0d", k), {31'd0, pch_b}, 32'd1);
            tick();
            idex_memread = 1'b0;
        end
        settle();
        chk("fresh_pch_done", {31'd0, pch_b}, 32'd0);
        chk("fresh_cnt", cnt_b, 32'd3);

        // Saturating counter: 20 frozen cycles
        do_reset();
        mem_busy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 14) begin
                chk("sat_cnt_15", {28'd0, cnt_c}, 32'd15);
            end
        end
        settle();
        chk("sat_cnt_c", {28'd0, cnt_c}, 32'd15);
        chk("sat_frz_c", {31'd0, frz_c}, 32'd1);
        chk("nosat_cnt_a", cnt_a, 32'd20);
        mem_busy = 1'b0;
        tick();
        chk("sat_cnt_idle", {28'd0, cnt_c}, 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard-control unit for the 5-stage ARMv8 pipeline.
- Generates per-operand EX-stage forward selects for NUM_SRC source operands, with EX/MEM over MEM/WB priority and a hard-wired zero register excluded.
- Adds load-use stall/bubble generation with configurable load latency, a global freeze while data memory is busy, and a saturating stall-cycle counter for performance reporting.
- Sits beside the ID/EX and EX/MEM pipeline registers and drives their enables and the EX operand muxes.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, number of source operands per instruction (2 or 3; 3 covers store-data/MADD Ra).
- ZERO_REG, 31, register index never forwarded and never treated as a hazard (XZR).
- LOAD_LAT, 1, cycles from load in EX until its data is forwardable from MEM/WB; range 1..7.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_src  in  NUM_SRC*REG_AW  ID/EX source register addresses; operand i is at bits [i*REG_AW +: REG_AW].
- id_src  in  NUM_SRC*REG_AW  IF/ID (decode) source register addresses.
- id_src_used  in  NUM_SRC  operand i is actually read by the decoding instruction.
- idex_rd  in  REG_AW  ID/EX destination register.
- idex_memread  in  1  instruction in EX is a load.
- exmem_rd  in  REG_AW  EX/MEM destination register.
- exmem_regwrite  in  1  EX/MEM writes a register.
- memwb_rd  in  REG_AW  MEM/WB destination register.
- memwb_regwrite  in  1  MEM/WB writes a register.
- mem_busy  in  1  data memory has not completed its access this cycle.
- fwd_sel  out  2*NUM_SRC  per operand: 00 register file, 10 EX/MEM, 01 MEM/WB.
- pc_hold  out  1  hold PC.
- ifid_hold  out  1  hold IF/ID.
- idex_bubble  out  1  load NOP into ID/EX.
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_hold=1.

Behaviour:
- Forwarding is combinational and evaluated per operand i.
  - 10 if exmem_regwrite, exmem_rd != ZERO_REG and exmem_rd == ex_src[i].
  - Otherwise 01 if memwb_regwrite, memwb_rd != ZERO_REG and memwb_rd == ex_src[i].
  - Otherwise 00.
  - Every output is assigned on every evaluation; no latches.
- Load-use hazard (lu) = idex_memread, idex_rd != ZERO_REG, and for some i, id_src_used[i] and id_src[i] == idex_rd.
- Registered state: st in {RUN, LU_WAIT}, wait counter wcnt (3 bits), stall_cycles.
- RUN:
  - If lu and !mem_busy: pc_hold=1, ifid_hold=1, idex_bubble=1.
  - Then, if LOAD_LAT>1, go to LU_WAIT with wcnt=LOAD_LAT-1; otherwise stay in RUN.
- LU_WAIT:
  - pc_hold=1, ifid_hold=1, idex_bubble=1 each cycle.
  - wcnt decrements when !mem_busy.
  - Return to RUN in the cycle after wcnt reaches 1 and decrements; total stall is LOAD_LAT cycles.
- Freeze on mem_busy=1, in either state:
  - pipe_freeze=1, pc_hold=1, ifid_hold=1, idex_bubble=0.
  - st and wcnt are held; no bubble is inserted while frozen.
- Simultaneous lu and mem_busy: the freeze wins; lu is re-evaluated on the first cycle mem_busy=0.
- stall_cycles increments on every cycle with pc_hold=1 and saturates at all-ones (no wrap).
- Reset (async assert, sync-released internally by rst_n deassert edge):
  - st=RUN, wcnt=0, stall_cycles=0.
  - Registers clear immediately on assertion, including mid-LU_WAIT.
  - Combinational outputs follow from cleared state and inputs.
- Port 3 (NUM_SRC=3) follows identical rules; unused operands with id_src_used=0 never cause a stall but are still forwarded.

Test Plan:
- exmem_regwrite=1, exmem_rd=5; memwb_regwrite=1, memwb_rd=5; ex_src={5,5} -> fwd_sel=10 for both (EX/MEM priority); then exmem_regwrite=0 -> 01 for both.
- exmem_rd=31 with regwrite=1, ex_src[0]=31 -> fwd_sel[0]=00; memwb_rd=7, ex_src[1]=7 -> fwd_sel[1]=01 (checks the Rm path is not inverted).
- LOAD_LAT=1: idex_memread=1, idex_rd=3, id_src[1]=3 used -> pc_hold/ifid_hold/idex_bubble high exactly 1 cycle; stall_cycles goes 0->1. Repeat with id_src_used[1]=0 -> no stall.
- LOAD_LAT=3, same load-use -> 3 consecutive stall cycles with bubble, back to RUN, stall_cycles=3; mem_busy=1 for 2 cycles inside LU_WAIT -> pipe_freeze=1, idex_bubble=0, total stall 5 cycles.
- Assert rst_n=0 mid-LU_WAIT -> all holds drop immediately, stall_cycles=0; after release, the next load-use stalls for a fresh LOAD_LAT.
- CNT_W=4: hold mem_busy=1 for 20 cycles -> stall_cycles saturates at 15.
